ripple_subtractor8: RTL
=======================

# ripple_subtractor8

Sequential ripple-borrow subtractor, the inverse of our strobed 8-bit ripple-carry adder. It uses the same enable/write/strobe/ready control protocol. The operation is split into 2-bit slices, evaluated one slice per clock from LSB to MSB. It sits beside the adder in the ALU datapath and produces a difference, a borrow flag and a zero flag.

## Interface
- WIDTH, 8, operand width; must be an even number ≥ 2. SLICES = WIDTH/2 is derived.

- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- rx_enable  in  1  block enable; registered once internally to give enable_q
- rx_write  in  1  operand write request; registered to give write_q
- rx_strobe  in  1  starts a subtraction
- rx_borrowflag  in  1  borrow-in to the LSB slice
- rx_minuend  in  WIDTH  minuend (unsigned)
- rx_subtrahend  in  WIDTH  subtrahend (unsigned)
- tx_difference  out  WIDTH  registered result
- tx_borrowflag  out  1  registered borrow-out of the MSB slice
- tx_zeroflag  out  1  registered; 1 when tx_difference == 0
- tx_ready  out  1  combinational; high when idle

## Operation
- Reset (areset sampled high):
  - enable_q, write_q, state, operands, borrow chain, tx_difference, tx_borrowflag and tx_zeroflag all go to 0.
  - tx_ready = 1.
- State is a one-hot shift register of SLICES bits.
  - IDLE = all zero.
  - SLICE_k = bit k set.
- Transitions, all gated by enable_q:
  - IDLE → SLICE_0 when rx_strobe = 1.
  - SLICE_k → SLICE_k+1.
  - SLICE_{SLICES-1} → IDLE.
  - enable_q = 0 freezes the state, the operands, the borrow chain and the outputs. The operation resumes when enable_q returns to 1.
  - rx_strobe is ignored when not in IDLE.
- write_q updates only when enable_q is high and the block is in IDLE; otherwise it holds.
- When enable_q, write_q and IDLE are all high: rx_minuend and rx_subtrahend are latched into the operand registers every cycle.
- On the accepted strobe edge, rx_borrowflag is latched into borrow_in.
- In SLICE_k, slice k computes {b_out, d[1:0]} = a[2k+:2] − s[2k+:2] − b_in.
  - b_in for slice 0 is the latched borrow_in; for slice k it is the registered b_out of slice k−1.
  - d goes into diff_acc[2k+:2]; b_out goes into the borrow register.
- On the SLICE_{SLICES-1} → IDLE edge:
  - tx_difference ← final diff_acc.
  - tx_borrowflag ← final b_out.
  - tx_zeroflag ← (final diff_acc == 0).
- Outputs hold until the next completion.
- Arithmetic:
  - tx_difference = (minuend − subtrahend − borrow_in) mod 2^WIDTH.
  - tx_borrowflag = 1 iff minuend < subtrahend + borrow_in, compared unsigned at WIDTH+1 bits.
- areset mid-operation: the block returns to IDLE on the next edge, the in-flight result is discarded and all outputs read 0.

## Timing
- rx_enable → enable_q: 1 cycle. rx_write → write_q: 1 cycle after enable_q is high.
- Operand latch and strobe may occur on the same edge; the slice datapath uses the latched operand values.
- Strobe accepted at edge T:
  - tx_ready is low from T+1 through T+SLICES.
  - Results are valid and tx_ready is high at T+SLICES+1. For WIDTH=8 that is 4 busy cycles.
- A strobe can be accepted again on the same edge at which tx_ready rises (back-to-back issue every SLICES+1 cycles).
- Each cycle enable_q is low during the busy phase adds exactly one cycle of latency.

## Structure
- Package ripple_subtractor_pkg holds:
  - localparam SLICE_W = 2;
  - a state typedef sized by SLICES;
  - the slice result struct {borrow, diff[1:0]}.
- Sub-module subtractor2: combinational 2-bit slice.
  - Inputs: a[1:0], s[1:0], b_in.
  - Outputs: d[1:0], b_out.
  - Generate SLICES instances, with a per-slice enable derived from state.

## Test plan
- Reset → tx_difference = 0x00, tx_borrowflag = 0, tx_zeroflag = 0, tx_ready = 1. Strobe with rx_enable low → no state change.
- 0x5A − 0x3C, borrow_in 0 → 0x1E, borrow 0, zero 0. tx_ready low for exactly 4 cycles after the strobe edge; result at T+5.
- 0x10 − 0x20, borrow_in 0 → 0xF0, borrow 1. Then 0x00 − 0x00, borrow_in 1 → 0xFF, borrow 1.
- 0x01 − 0x00, borrow_in 1 → 0x00, zero 1, borrow 0. Follow with a back-to-back strobe of 0xFF − 0x01 → 0xFE, zero 0.
- Strobe re-asserted during SLICE_1 → ignored. rx_enable dropped for 3 cycles while in SLICE_1 → result delayed by exactly 3 cycles and unchanged.
- areset pulsed in SLICE_2 of 0x80 − 0x01 → IDLE next cycle, outputs 0, no 0x7F ever appears. The next full operation completes correctly.

Source files
------------

// File: rtl/ripple_subtractor_pkg.sv
// Shared types for the sequential ripple-borrow subtractor.
// Slice width, default state vector and per-slice result bundle.
package ripple_subtractor_pkg;

   localparam int SLICE_W    = 2;
   localparam int WIDTH_DEF  = 8;
   localparam int SLICES_DEF = WIDTH_DEF / SLICE_W;

   // One-hot slice pointer; all-zero means idle.
   typedef logic [SLICES_DEF-1:0] state_t;

   // Packed so {borrow, diff} is the 3-bit two's-complement result.
   typedef struct packed {
      logic               borrow;
      logic [SLICE_W-1:0] diff;
   } slice_res_t;

endpackage

// File: rtl/ripple_subtractor8_subtractor2.sv
// Combinational 2-bit subtract slice with borrow in/out.
// Ports: a, s (2-bit operands), b_in -> d (2-bit difference), b_out.
module subtractor2
   import ripple_subtractor_pkg::*;
(
   input  logic [1:0] a,
   input  logic [1:0] s,
   input  logic       b_in,
   output logic [1:0] d,
   output logic       b_out
);

   slice_res_t res;

   // A borrow shows up as the wrap into bit 2.
   always_comb begin
      res = slice_res_t'({1'b0, a} - {1'b0, s} - {2'b00, b_in});
   end

   assign d     = res.diff;
   assign b_out = res.borrow;

endmodule

// File: rtl/ripple_subtractor8.sv
// Sequential ripple-borrow subtractor, one 2-bit slice per clock.
// Ports: aclk, areset, rx_* controls/operands, tx_* result/flags, tx_ready.
module ripple_subtractor8
   import ripple_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             rx_enable,
   input  logic             rx_write,
   input  logic             rx_strobe,
   input  logic             rx_borrowflag,
   input  logic [WIDTH-1:0] rx_minuend,
   input  logic [WIDTH-1:0] rx_subtrahend,
   output logic [WIDTH-1:0] tx_difference,
   output logic             tx_borrowflag,
   output logic             tx_zeroflag,
   output logic             tx_ready
);

   localparam int SLICES = WIDTH / SLICE_W;

   logic              enable_q;
   logic              write_q;
   logic [SLICES-1:0] state;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  ops;
   logic [WIDTH-1:0]  diff_acc;
   logic              borrow_in;
   logic              borrow_r;

   logic              idle;
   logic              last;

   logic [SLICES-1:0][1:0] sd;
   logic [SLICES-1:0]      sb;
   logic [SLICES-1:0]      sb_en;
   logic [SLICES-1:0]      bin;

   logic [WIDTH-1:0]  diff_next;
   logic              b_next;

   assign idle     = (state == '0);
   assign last     = state[SLICES-1];
   assign tx_ready = idle;

   for (genvar k = 0; k < SLICES; k++) begin : g_slice
      // Slice 0 takes the latched borrow-in, the rest ripple
      // through the single borrow register.
      if (k == 0) begin : g_first
         assign bin[k] = borrow_in;
      end else begin : g_rest
         assign bin[k] = borrow_r;
      end

      subtractor2 u_slice (
         .a     (opa[k*SLICE_W +: SLICE_W]),
         .s     (ops[k*SLICE_W +: SLICE_W]),
         .b_in  (bin[k]),
         .d     (sd[k]),
         .b_out (sb[k])
      );

      assign sb_en[k] = sb[k] & state[k];
   end

   // Merge the active slice into the accumulator.
   always_comb begin
      diff_next = diff_acc;
      for (int k = 0; k < SLICES; k++) begin
         if (state[k]) begin
            diff_next[k*SLICE_W +: SLICE_W] = sd[k];
         end
      end
      b_next = |sb_en;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         enable_q      <= 1'b0;
         write_q       <= 1'b0;
         state         <= '0;
         opa           <= '0;
         ops           <= '0;
         diff_acc      <= '0;
         borrow_in     <= 1'b0;
         borrow_r      <= 1'b0;
         tx_difference <= '0;
         tx_borrowflag <= 1'b0;
         tx_zeroflag   <= 1'b0;
      end else begin
         enable_q <= rx_enable;
         if (enable_q) begin
            if (idle) begin
               write_q <= rx_write;
               if (write_q) begin
                  opa <= rx_minuend;
                  ops <= rx_subtrahend;
               end
               if (rx_strobe) begin
                  state     <= SLICES'(1);
                  borrow_in <= rx_borrowflag;
               end
            end else begin
               // Last slice shifts out to all-zero, i.e. idle.
               state    <= state << 1;
               borrow_r <= b_next;
               diff_acc <= diff_next;
               if (last) begin
                  tx_difference <= diff_next;
                  tx_borrowflag <= b_next;
                  tx_zeroflag   <= (diff_next == '0);
               end
            end
         end
      end
   end

endmodule
